ibex_cheri_tag_ctrl: RTL and testbench

Tag controller sitting directly upstream of the CHERI tag memory (ibex_cheri_tag_mem). Translates LSU byte-address requests into tag-granule indices, enforces capability tag rules, and drives the single tag-memory port. Data stores clear the tag of the granule they touch, and misaligned capability accesses are flagged. Also runs a sequential range-clear sweep used for revocation and boot scrubbing.

---
 rtl/ibex_cheri_pkg.sv | 12 +
 rtl/ibex_cheri_tag_idx.sv | 24 ++
 rtl/ibex_cheri_tag_ctrl.sv | 177 +++++++++++++++++
 tb/tb_ibex_cheri_tag_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_cheri_pkg.sv
// Shared constants and types for the CHERI tag controller slice.
package ibex_cheri_pkg;

    // Capabilities are 8 bytes, so one tag bit covers one 8-byte granule.
    localparam int unsigned CAP_BYTES_LOG2_DEFAULT = 3;

    typedef enum logic [0:0] {
        TC_IDLE  = 1'b0,
        TC_CLEAR = 1'b1
    } tag_ctrl_state_e;

endpackage

// File: rtl/ibex_cheri_tag_idx.sv
// Byte address to tag-granule index conversion, with range and alignment checks.
module ibex_cheri_tag_idx
    import ibex_cheri_pkg::*;
#(
    parameter int unsigned TAG_MEM_SIZE   = 128000,
    parameter logic [31:0] MEM_BASE       = 32'h0010_0000,
    parameter int unsigned CAP_BYTES_LOG2 = CAP_BYTES_LOG2_DEFAULT
) (
    input  logic [31:0] addr_i,
    output logic [31:0] idx_o,
    output logic        oor_o,
    output logic        aligned_o
);

    logic [31:0] offset;

    // Addresses below the base wrap to a huge offset; the explicit compare
    // catches them even if the wrapped index happens to fall inside the memory.
    assign offset    = addr_i - MEM_BASE;
    assign idx_o     = offset >> CAP_BYTES_LOG2;
    assign oor_o     = (addr_i < MEM_BASE) || (idx_o >= 32'(TAG_MEM_SIZE));
    assign aligned_o = (addr_i[CAP_BYTES_LOG2-1:0] == '0);

endmodule

// File: rtl/ibex_cheri_tag_ctrl.sv
// Tag controller in front of the single-port CHERI tag memory.
//
// state    | meaning
// ---------+------------------------------------------------------------
// TC_IDLE  | serve LSU requests, one per cycle; accept range-clear start
// TC_CLEAR | sweep: write 0 to one granule per cycle, LSU stalled
module ibex_cheri_tag_ctrl
    import ibex_cheri_pkg::*;
#(
    parameter int unsigned TAG_MEM_SIZE   = 128000,
    parameter logic [31:0] MEM_BASE       = 32'h0010_0000,
    parameter int unsigned CAP_BYTES_LOG2 = CAP_BYTES_LOG2_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic        cap_i,
    input  logic        tag_wdata_i,
    output logic        rvalid_o,
    output logic        tag_rdata_o,
    output logic        err_o,
    input  logic        clr_start_i,
    input  logic [31:0] clr_addr_i,
    input  logic [31:0] clr_len_i,
    output logic        clr_busy_o,
    output logic        clr_done_o,
    output logic [31:0] tmem_addr_o,
    output logic        tmem_we_o,
    output logic        tmem_wdata_o,
    input  logic        tmem_rdata_i
);

    tag_ctrl_state_e state_q, state_d;
    logic [31:0]     clr_idx_q, clr_idx_d;
    logic [31:0]     clr_cnt_q, clr_cnt_d;
    logic [31:0]     clr_idx_next;
    logic            done_q, done_d;
    logic            rvalid_q, rvalid_d;
    logic            rsp_rd_q, rsp_rd_d;
    logic            err_q, err_d;

    logic [31:0]     req_idx;
    logic            req_oor;
    logic            req_aligned;
    logic [31:0]     clr_start_idx;
    logic            clr_start_oor;
    logic            clr_aligned_unused;

    logic            gnt;
    logic [31:0]     mem_addr;
    logic            mem_we;
    logic            mem_wdata;

    ibex_cheri_tag_idx #(
        .TAG_MEM_SIZE  (TAG_MEM_SIZE),
        .MEM_BASE      (MEM_BASE),
        .CAP_BYTES_LOG2(CAP_BYTES_LOG2)
    ) u_req_idx (
        .addr_i   (addr_i),
        .idx_o    (req_idx),
        .oor_o    (req_oor),
        .aligned_o(req_aligned)
    );

    // The sweep start is rounded down to its granule, so its alignment is irrelevant.
    ibex_cheri_tag_idx #(
        .TAG_MEM_SIZE  (TAG_MEM_SIZE),
        .MEM_BASE      (MEM_BASE),
        .CAP_BYTES_LOG2(CAP_BYTES_LOG2)
    ) u_clr_idx (
        .addr_i   (clr_addr_i),
        .idx_o    (clr_start_idx),
        .oor_o    (clr_start_oor),
        .aligned_o(clr_aligned_unused)
    );

    assign clr_idx_next = clr_idx_q + 32'd1;

    // Next-state, tag-memory drive and response capture.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        clr_cnt_d = clr_cnt_q;
        done_d    = 1'b0;
        rvalid_d  = 1'b0;
        rsp_rd_d  = 1'b0;
        err_d     = 1'b0;
        gnt       = 1'b0;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = 1'b0;

        case (state_q)
            TC_IDLE: begin
                if (clr_start_i) begin
                    // Empty or out-of-range sweeps complete immediately with no writes.
                    if ((clr_len_i == '0) || clr_start_oor) begin
                        done_d = 1'b1;
                    end else begin
                        state_d   = TC_CLEAR;
                        clr_idx_d = clr_start_idx;
                        clr_cnt_d = clr_len_i;
                    end
                end else if (req_i) begin
                    gnt      = 1'b1;
                    rvalid_d = 1'b1;
                    err_d    = cap_i & ~req_aligned;
                    if (!req_oor) begin
                        if (we_i && !cap_i) begin
                            // Any data store invalidates the capability in that granule.
                            mem_addr  = req_idx;
                            mem_we    = 1'b1;
                            mem_wdata = 1'b0;
                        end else if (cap_i && req_aligned) begin
                            mem_addr  = req_idx;
                            mem_we    = we_i;
                            mem_wdata = we_i & tag_wdata_i;
                            rsp_rd_d  = ~we_i;
                        end
                    end
                end
            end
            TC_CLEAR: begin
                mem_addr  = clr_idx_q;
                mem_we    = 1'b1;
                mem_wdata = 1'b0;
                clr_idx_d = clr_idx_next;
                clr_cnt_d = clr_cnt_q - 32'd1;
                // Stop after the last requested granule or at the end of tag memory.
                if ((clr_cnt_q == 32'd1) || (clr_idx_next >= 32'(TAG_MEM_SIZE))) begin
                    state_d = TC_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = TC_IDLE;
            end
        endcase
    end

    // State and response registers; synchronous reset drops any pending response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= TC_IDLE;
            clr_idx_q <= '0;
            clr_cnt_q <= '0;
            done_q    <= 1'b0;
            rvalid_q  <= 1'b0;
            rsp_rd_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            clr_cnt_q <= clr_cnt_d;
            done_q    <= done_d;
            rvalid_q  <= rvalid_d;
            rsp_rd_q  <= rsp_rd_d;
            err_q     <= err_d;
        end
    end

    // Outputs are held quiet while reset is asserted so an in-flight sweep
    // cannot write one more granule during the reset cycle.
    assign gnt_o        = gnt & ~rst_i;
    assign tmem_we_o    = mem_we & ~rst_i;
    assign tmem_wdata_o = mem_wdata & ~rst_i;
    assign tmem_addr_o  = rst_i ? '0 : mem_addr;
    assign clr_busy_o   = (state_q == TC_CLEAR) & ~rst_i;
    assign clr_done_o   = done_q & ~rst_i;
    assign rvalid_o     = rvalid_q & ~rst_i;
    assign err_o        = rvalid_q & err_q & ~rst_i;
    assign tag_rdata_o  = rvalid_q & rsp_rd_q & tmem_rdata_i & ~rst_i;

endmodule

// File: tb/tb_ibex_cheri_tag_ctrl.sv
// Self-checking bench for the CHERI tag controller with a behavioural tag memory.
module tb_ibex_cheri_tag_ctrl;

    localparam int          TMS  = 128000;
    localparam logic [31:0] BASE = 32'h0010_0000;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i, gnt_o;
    logic [31:0] addr_i;
    logic        we_i, cap_i, tag_wdata_i;
    logic        rvalid_o, tag_rdata_o, err_o;
    logic        clr_start_i;
    logic [31:0] clr_addr_i, clr_len_i;
    logic        clr_busy_o, clr_done_o;
    logic [31:0] tmem_addr_o;
    logic        tmem_we_o, tmem_wdata_o;
    logic        tmem_rdata_i = 1'b0;

    ibex_cheri_tag_ctrl #(
        .TAG_MEM_SIZE  (TMS),
        .MEM_BASE      (BASE),
        .CAP_BYTES_LOG2(3)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (req_i),
        .gnt_o       (gnt_o),
        .addr_i      (addr_i),
        .we_i        (we_i),
        .cap_i       (cap_i),
        .tag_wdata_i (tag_wdata_i),
        .rvalid_o    (rvalid_o),
        .tag_rdata_o (tag_rdata_o),
        .err_o       (err_o),
        .clr_start_i (clr_start_i),
        .clr_addr_i  (clr_addr_i),
        .clr_len_i   (clr_len_i),
        .clr_busy_o  (clr_busy_o),
        .clr_done_o  (clr_done_o),
        .tmem_addr_o (tmem_addr_o),
        .tmem_we_o   (tmem_we_o),
        .tmem_wdata_o(tmem_wdata_o),
        .tmem_rdata_i(tmem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int bad_wr = 0;

    bit tag_mem  [TMS];
    bit ref_tags [TMS];

    typedef struct {
        logic tag;
        logic err;
        int   cyc;
    } rsp_t;
    rsp_t rsp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    always @(posedge clk_i) cyc <= cyc + 1;

    // Behavioural tag memory: registered read on every non-write cycle.
    always @(posedge clk_i) begin
        if (tmem_we_o) begin
            if (tmem_addr_o < TMS) tag_mem[tmem_addr_o] <= tmem_wdata_o;
            else bad_wr <= bad_wr + 1;
        end else begin
            tmem_rdata_i <= (tmem_addr_o < TMS) ? tag_mem[tmem_addr_o] : 1'b0;
        end
    end

    // Response monitor: pops the scoreboard whenever the DUT presents a response.
    always @(negedge clk_i) begin
        if (!rst_i && rvalid_o) begin
            if (rsp_q.size() == 0) begin
                check_eq("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                rsp_t r;
                r = rsp_q.pop_front();
                check_eq("rsp_cycle", cyc, r.cyc);
                check_eq("rsp_tag", tag_rdata_o, r.tag);
                check_eq("rsp_err", err_o, r.err);
            end
        end
    end

    // One LSU request; the expected memory drive and response come from the bench's own model.
    task automatic lsu_req(input logic we, input logic cap, input logic [31:0] a, input logic tw);
        logic [31:0] off, idx;
        logic        oor, aligned, acc, ewe, ewd, etag, eerr;
        rsp_t        r;
        off     = a - BASE;
        idx     = off >> 3;
        oor     = (a < BASE) || (idx >= TMS);
        aligned = (a[2:0] == 3'd0);
        acc     = !oor && ((we && !cap) || (cap && aligned));
        ewe     = acc && we;
        ewd     = we && cap && tw;
        eerr    = cap && !aligned;
        etag    = acc && !we ? ref_tags[idx] : 1'b0;
        @(posedge clk_i); #1;
        req_i = 1'b1; we_i = we; cap_i = cap; addr_i = a; tag_wdata_i = tw; clr_start_i = 1'b0;
        #2;
        check_eq("req_gnt", gnt_o, 1'b1);
        check_eq("req_tmem_we", tmem_we_o, ewe);
        if (acc) check_eq("req_tmem_addr", tmem_addr_o, idx);
        if (ewe) check_eq("req_tmem_wdata", tmem_wdata_o, ewd);
        r.tag = etag; r.err = eerr; r.cyc = cyc + 1;
        rsp_q.push_back(r);
        if (ewe) ref_tags[idx] = ewd;
    endtask

    task automatic go_idle();
        @(posedge clk_i); #1;
        req_i = 1'b0; clr_start_i = 1'b0;
    endtask

    // Range clear; optionally holds an LSU cap load of granule 0 throughout.
    task automatic run_sweep(input logic [31:0] a, input logic [31:0] len, input int first,
                             input int nwr, input logic hold);
        rsp_t r;
        @(posedge clk_i); #1;
        clr_start_i = 1'b1; clr_addr_i = a; clr_len_i = len;
        req_i = hold; we_i = 1'b0; cap_i = 1'b1; addr_i = BASE; tag_wdata_i = 1'b0;
        #2;
        check_eq("start_gnt", gnt_o, 1'b0);
        check_eq("start_busy", clr_busy_o, 1'b0);
        check_eq("start_tmem_we", tmem_we_o, 1'b0);
        for (int k = 0; k < nwr; k++) begin
            @(posedge clk_i); #1;
            clr_start_i = (k == 1);
            #2;
            check_eq("sweep_busy", clr_busy_o, 1'b1);
            check_eq("sweep_gnt", gnt_o, 1'b0);
            check_eq("sweep_we", tmem_we_o, 1'b1);
            check_eq("sweep_addr", tmem_addr_o, first + k);
            check_eq("sweep_wdata", tmem_wdata_o, 1'b0);
            check_eq("sweep_done_early", clr_done_o, 1'b0);
            ref_tags[first + k] = 1'b0;
        end
        @(posedge clk_i); #1;
        clr_start_i = 1'b0;
        #2;
        check_eq("end_busy", clr_busy_o, 1'b0);
        check_eq("end_done", clr_done_o, 1'b1);
        if (hold) begin
            check_eq("end_gnt", gnt_o, 1'b1);
            r.tag = ref_tags[0]; r.err = 1'b0; r.cyc = cyc + 1;
            rsp_q.push_back(r);
        end else begin
            check_eq("end_tmem_we", tmem_we_o, 1'b0);
        end
        @(posedge clk_i); #1;
        req_i = 1'b0;
        #2;
        check_eq("post_done", clr_done_o, 1'b0);
        check_eq("post_busy", clr_busy_o, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; req_i = 1'b0; addr_i = '0; we_i = 1'b0; cap_i = 1'b0; tag_wdata_i = 1'b0;
        clr_start_i = 1'b0; clr_addr_i = '0; clr_len_i = '0;
        repeat (3) @(posedge clk_i);
        #3;
        check_eq("rst_gnt", gnt_o, 1'b0);
        check_eq("rst_rvalid", rvalid_o, 1'b0);
        check_eq("rst_busy", clr_busy_o, 1'b0);
        check_eq("rst_done", clr_done_o, 1'b0);
        check_eq("rst_tmem_we", tmem_we_o, 1'b0);
        check_eq("rst_tmem_addr", tmem_addr_o, 32'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        // Cap store then cap load back-to-back, data store clears, misaligned, data load.
        lsu_req(1'b1, 1'b1, 32'h0010_0010, 1'b1);
        lsu_req(1'b0, 1'b1, 32'h0010_0010, 1'b0);
        lsu_req(1'b1, 1'b0, 32'h0010_0013, 1'b0);
        lsu_req(1'b0, 1'b1, 32'h0010_0010, 1'b0);
        lsu_req(1'b0, 1'b1, 32'h0010_0014, 1'b0);
        lsu_req(1'b0, 1'b0, 32'h0010_0010, 1'b0);

        // Range boundaries: below base, first index past the end, last valid index.
        lsu_req(1'b1, 1'b1, 32'h000F_FFF8, 1'b1);
        lsu_req(1'b0, 1'b1, 32'h000F_FFF8, 1'b0);
        lsu_req(1'b1, 1'b1, 32'h001F_A000, 1'b1);
        lsu_req(1'b0, 1'b1, 32'h001F_A000, 1'b0);
        lsu_req(1'b1, 1'b1, 32'h001F_9FF8, 1'b1);
        lsu_req(1'b0, 1'b1, 32'h001F_9FF8, 1'b0);
        go_idle();

        // Sweep of idx 1..3 with a held request and a start pulse while busy.
        for (int i = 0; i < 5; i++) lsu_req(1'b1, 1'b1, BASE + 32'(8 * i), 1'b1);
        go_idle();
        run_sweep(32'h0010_0008, 32'd3, 1, 3, 1'b1);
        for (int i = 0; i < 5; i++) lsu_req(1'b0, 1'b1, BASE + 32'(8 * i), 1'b0);
        go_idle();

        // Reset after the first sweep write.
        for (int i = 0; i < 5; i++) lsu_req(1'b1, 1'b1, BASE + 32'(8 * i), 1'b1);
        go_idle();
        @(posedge clk_i); #1;
        clr_start_i = 1'b1; clr_addr_i = 32'h0010_0008; clr_len_i = 32'd3;
        @(posedge clk_i); #1;
        clr_start_i = 1'b0;
        #2;
        check_eq("rsw_we", tmem_we_o, 1'b1);
        check_eq("rsw_addr", tmem_addr_o, 32'd1);
        ref_tags[1] = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        #2;
        check_eq("rsw_rst_we", tmem_we_o, 1'b0);
        check_eq("rsw_rst_busy", clr_busy_o, 1'b0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        #2;
        check_eq("rsw_busy", clr_busy_o, 1'b0);
        check_eq("rsw_done", clr_done_o, 1'b0);
        check_eq("rsw_we_after", tmem_we_o, 1'b0);
        @(posedge clk_i); #3;
        check_eq("rsw_done2", clr_done_o, 1'b0);
        for (int i = 0; i < 5; i++) lsu_req(1'b0, 1'b1, BASE + 32'(8 * i), 1'b0);
        go_idle();

        // Zero length, clamp at end of memory, start below base.
        run_sweep(32'h0010_0008, 32'd0, 0, 0, 1'b0);
        lsu_req(1'b1, 1'b1, 32'h001F_9FF0, 1'b1);
        go_idle();
        run_sweep(32'h001F_9FF0, 32'd5, 127998, 2, 1'b0);
        lsu_req(1'b0, 1'b1, 32'h001F_9FF0, 1'b0);
        lsu_req(1'b0, 1'b1, 32'h001F_9FF8, 1'b0);
        go_idle();
        run_sweep(32'h000F_FFF0, 32'd4, 0, 0, 1'b0);
        lsu_req(1'b0, 1'b1, BASE, 1'b0);
        lsu_req(1'b0, 1'b1, BASE + 32'd16, 1'b0);
        go_idle();

        repeat (3) @(posedge clk_i);
        #3;
        check_eq("rsp_outstanding", rsp_q.size(), 32'd0);
        check_eq("oor_writes", bad_wr, 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
